// File: rtl/mem_arbiter.sv
// +------------------------------------------------------------------+
// | mem_arbiter : shares one memory bus between fetch and data ports |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  input  logic              d_ce_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              stall_req_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_I_ACC = 2'd1;
  localparam logic [1:0] S_D_ACC = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_ready_q, d_ready_d;
  logic              err_q, err_d;
  logic [3:0]        streak_q, streak_d;
  logic [7:0]        tmo_q, tmo_d;

  logic in_idle, in_acc, serve_i;
  logic if_req, d_req, streak_at_max;
  logic grant_if, grant_d;
  logic finish_ok, finish_tmo, finish;

  // A requester whose ready is high this cycle is still holding its old request.
  assign if_req        = if_ce_i & ~if_ready_q;
  assign d_req         = d_ce_i & ~d_ready_q;
  assign streak_at_max = (streak_q == STREAK_MAX);

  assign in_idle    = (state_q == S_IDLE);
  assign in_acc     = (state_q == S_I_ACC) || (state_q == S_D_ACC);
  assign serve_i    = (state_q == S_I_ACC);
  assign grant_if   = in_idle & if_req & (~d_req | streak_at_max);
  assign grant_d    = in_idle & d_req & ~grant_if;
  assign finish_ok  = in_acc & bus_ack_i;
  assign finish_tmo = in_acc & ~bus_ack_i & (tmo_q == TMO_LAST);
  assign finish     = finish_ok | finish_tmo;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'h0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_data_q   <= '0;
      if_ready_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
      streak_q    <= 4'd0;
      tmo_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_data_q   <= if_data_d;
      if_ready_q  <= if_ready_d;
      d_rdata_q   <= d_rdata_d;
      d_ready_q   <= d_ready_d;
      err_q       <= err_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_if)     state_d = S_I_ACC;
        else if (grant_d) state_d = S_D_ACC;
      end
      S_I_ACC, S_D_ACC: begin
        if (finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_data_d   = if_data_q;
    if_ready_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_ready_d   = 1'b0;
    err_d       = 1'b0;
    streak_d    = streak_q;
    tmo_d       = tmo_q;

    if (grant_if) begin
      bus_req_d   = 1'b1;
      bus_we_d    = 1'b0;
      bus_sel_d   = 4'hF;
      bus_addr_d  = if_addr_i;
      bus_wdata_d = '0;
      tmo_d       = 8'd0;
      streak_d    = 4'd0;
    end else if (grant_d) begin
      bus_req_d   = 1'b1;
      bus_we_d    = d_we_i;
      bus_sel_d   = d_sel_i;
      bus_addr_d  = d_addr_i;
      bus_wdata_d = d_wdata_i;
      tmo_d       = 8'd0;
      // Only data wins that leave a fetch waiting count toward starvation.
      if (if_req) streak_d = streak_at_max ? STREAK_MAX : streak_q + 4'd1;
      else        streak_d = 4'd0;
    end else if (finish) begin
      bus_req_d = 1'b0;
      err_d     = finish_tmo;
      if (serve_i) begin
        if_ready_d = 1'b1;
        if_data_d  = finish_ok ? bus_rdata_i : '0;
      end else begin
        d_ready_d = 1'b1;
        d_rdata_d = finish_ok ? bus_rdata_i : '0;
      end
    end else if (in_acc) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_data_o   = if_data_q;
  assign if_ready_o  = if_ready_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ready_o   = d_ready_q;
  assign err_o       = err_q;
  assign stall_req_o = (if_ce_i & ~if_ready_q) | (d_ce_i & ~d_ready_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +------------------------------------------------------------------+
// | tb_mem_arbiter : randomized requesters and bus vs reference model |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  localparam int TO = 8;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_ce_i, d_ce_i, d_we_i, bus_ack_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, bus_rdata_i;
  logic [3:0]  d_sel_i;
  logic [31:0] if_data_o, d_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_ready_o, d_ready_o, stall_req_o, err_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_sel_o;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
    .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .stall_req_o(stall_req_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Backing memory seen by the bus; unwritten words read as ~address.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  // Model state: previous-cycle inputs/outputs and the transaction in flight.
  bit          p_bus_req, p_if_ce, p_d_ce, p_ack, p_if_rdy, p_d_rdy;
  logic [31:0] p_rdata;
  bit          own_d;
  int          cyc, delay, streak;
  logic [31:0] g_addr, g_wd, exp_if_data, exp_d_data, wv;
  logic [3:0]  g_sel;
  bit          g_we;
  bit          if_act, if_fly, d_act, d_fly;
  logic [31:0] if_a, d_a, d_wd;
  logic [3:0]  d_sel;
  bit          d_we;
  bit          done, e_if, e_d, f, dq;

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, 32'(bus_req_o), 32'd0);
    chk({tag, "_bus_we"},  32'(bus_we_o), 32'd0);
    chk({tag, "_bus_sel"}, 32'(bus_sel_o), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr_o, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 32'd0);
    chk({tag, "_if_ready"}, 32'(if_ready_o), 32'd0);
    chk({tag, "_d_ready"}, 32'(d_ready_o), 32'd0);
    chk({tag, "_if_data"}, if_data_o, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata_o, 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    if_ce_i = 0; d_ce_i = 0; d_we_i = 0; bus_ack_i = 0;
    if_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; bus_rdata_i = 0; d_sel_i = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_stall", 32'(stall_req_o), 32'd0);
    rst_n = 1'b1;

    p_bus_req = 0; p_if_ce = 0; p_d_ce = 0; p_ack = 0; p_if_rdy = 0; p_d_rdy = 0;
    p_rdata = 0; own_d = 0; cyc = 0; delay = 0; streak = 0;
    exp_if_data = 0; exp_d_data = 0;
    if_act = 0; if_fly = 0; d_act = 0; d_fly = 0;

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      // Completion: ack seen last cycle, or TO bus cycles elapsed without one.
      done = p_bus_req && (p_ack || cyc == TO);
      e_if = done && !own_d;
      e_d  = done && own_d;
      chk("if_ready", 32'(if_ready_o), 32'(e_if));
      chk("d_ready",  32'(d_ready_o),  32'(e_d));
      chk("err",      32'(err_o),      32'(done && !p_ack));
      if (e_if) exp_if_data = p_ack ? p_rdata : 32'd0;
      if (e_d)  exp_d_data  = p_ack ? p_rdata : 32'd0;
      chk("if_data", if_data_o, exp_if_data);
      chk("d_rdata", d_rdata_o, exp_d_data);
      chk("stall", 32'(stall_req_o),
          32'((if_ce_i && !if_ready_o) || (d_ce_i && !d_ready_o)));

      f  = p_if_ce && !p_if_rdy;
      dq = p_d_ce && !p_d_rdy;
      if (p_bus_req && !done) begin
        chk("bus_req_hold", 32'(bus_req_o), 32'd1);
        chk("hold_addr", bus_addr_o, g_addr);
        chk("hold_we", 32'(bus_we_o), 32'(g_we));
        chk("hold_sel", 32'(bus_sel_o), 32'(g_sel));
        if (g_we) chk("hold_wdata", bus_wdata_o, g_wd);
        cyc++;
      end else if (p_bus_req) begin
        chk("bus_req_drop", 32'(bus_req_o), 32'd0);
      end else begin
        chk("grant", 32'(bus_req_o), 32'(f || dq));
        if (f || dq) begin
          own_d = !(f && (!dq || streak == SL));
          if (own_d) begin
            streak = f ? ((streak < SL) ? streak + 1 : SL) : 0;
            g_addr = d_a; g_we = d_we; g_sel = d_sel; g_wd = d_wd;
            chk("grant_wdata", bus_wdata_o, g_wd);
            d_fly = 1;
          end else begin
            streak = 0;
            g_addr = if_a; g_we = 0; g_sel = 4'hF;
            if_fly = 1;
          end
          chk("grant_addr", bus_addr_o, g_addr);
          chk("grant_we", 32'(bus_we_o), 32'(g_we));
          chk("grant_sel", 32'(bus_sel_o), 32'(g_sel));
          cyc = 1;
          case ($urandom_range(0, 9))
            0, 1:    delay = 1000;
            2:       delay = TO - 1;
            default: delay = $urandom_range(0, 4);
          endcase
        end
      end

      // Requesters: hold until ready; occasionally drop ce while being served.
      if (if_ready_o) begin if_fly = 0; if_act = 0; end
      if (d_ready_o)  begin d_fly = 0; d_act = 0; end
      if (if_fly && $urandom_range(0, 15) == 0) if_act = 0;
      if (d_fly && $urandom_range(0, 15) == 0)  d_act = 0;
      if (!if_act && !if_fly && $urandom_range(0, 2) != 0) begin
        if_act = 1;
        if_a   = 32'($urandom_range(0, 15)) << 2;
      end
      if (!d_act && !d_fly && $urandom_range(0, 3) != 0) begin
        d_act = 1;
        d_we  = 1'($urandom_range(0, 1));
        d_sel = 4'($urandom_range(1, 15));
        d_a   = 32'($urandom_range(0, 15)) << 2;
        d_wd  = $urandom;
      end
      if_ce_i = if_act; if_addr_i = if_a;
      d_ce_i = d_act; d_we_i = d_we; d_sel_i = d_sel; d_addr_i = d_a; d_wdata_i = d_wd;

      // Bus responder, plus stray acks while idle.
      bus_ack_i = 0;
      bus_rdata_i = $urandom;
      if (bus_req_o) begin
        if (cyc - 1 == delay) begin
          bus_ack_i = 1;
          if (g_we) begin
            wv = mem_rd(g_addr);
            for (int b = 0; b < 4; b++)
              if (g_sel[b]) wv[8*b +: 8] = g_wd[8*b +: 8];
            mem[g_addr] = wv;
          end else begin
            bus_rdata_i = mem_rd(g_addr);
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus_ack_i = 1;
      end

      p_bus_req = bus_req_o; p_if_ce = if_ce_i; p_d_ce = d_ce_i;
      p_ack = bus_ack_i; p_rdata = bus_rdata_i;
      p_if_rdy = if_ready_o; p_d_rdy = d_ready_o;
    end

    // Reset wherever the random run left the bus.
    rst_n = 1'b0; if_ce_i = 0; d_ce_i = 0; bus_ack_i = 0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst_n = 1'b1;

    // Reset during a data write that has been granted but not acked.
    d_ce_i = 1; d_we_i = 1; d_sel_i = 4'b0011; d_addr_i = 32'h8000; d_wdata_i = 32'hABCD;
    @(negedge clk);
    chk("dacc_req", 32'(bus_req_o), 32'd1);
    chk("dacc_we", 32'(bus_we_o), 32'd1);
    chk("dacc_sel", 32'(bus_sel_o), 32'h3);
    chk("dacc_addr", bus_addr_o, 32'h8000);
    d_ce_i = 0; rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("dacc_reset");
    rst_n = 1'b1; bus_ack_i = 1; bus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    bus_ack_i = 0;
    for (int k = 0; k < 3; k++) begin
      chk("late_ack_no_ready", 32'(d_ready_o), 32'd0);
      chk("late_ack_no_req", 32'(bus_req_o), 32'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
